trps_bank_ctrl: RTL

TRPS_BANK_CTRL -- requirements
Module: trps_bank_ctrl

---
 rtl/fht_pkg.sv | 17 +
 rtl/trps_bank_ctrl_if.sv | 37 +++
 rtl/trps_bank_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/fht_pkg.sv
// Shared block geometry and RAM sizing for the transpose bank controller.
// trps_addr maps a row-major write order onto a column-major read order.
package fht_pkg;

  localparam int BLK_WORDS = 64;
  localparam int BLK_DIM   = 8;
  localparam int RAM_AW    = 7;
  localparam int RAM_DW    = 16;
  localparam int CNT_W     = $clog2(BLK_WORDS);
  localparam int DIM_W     = $clog2(BLK_DIM);

  // Swapping the row and column halves of the counter walks the block column-first.
  function automatic logic [RAM_AW-1:0] trps_addr(input logic bank, input logic [CNT_W-1:0] cnt);
    return {bank, cnt[DIM_W-1:0], cnt[CNT_W-1:DIM_W]};
  endfunction

endpackage

// File: rtl/trps_bank_ctrl_if.sv
// Stream, DPSRAM and status signals of the transpose bank controller.
// Handshake: a word moves when valid and ready are both high on a rising edge; valid must not depend on ready.
interface trps_bank_ctrl_if #(parameter int N = 8);
  import fht_pkg::*;

  logic              inp_valid;
  logic [N-1:0]      inp_data;
  logic              inp_ready;

  logic [RAM_AW-1:0] wr_addr;
  logic              wr_en;
  logic [RAM_DW-1:0] wr_data;
  logic [RAM_AW-1:0] rd_addr;
  logic              rd_en;
  logic [RAM_DW-1:0] rd_data;

  logic              out_valid;
  logic [N-1:0]      out_data;
  logic              out_ready;
  logic              out_last;

  logic [1:0]        bank_full;
  logic              ovf;

  modport master (
    output inp_valid, inp_data, rd_data, out_ready,
    input  inp_ready, wr_addr, wr_en, wr_data, rd_addr, rd_en,
           out_valid, out_data, out_last, bank_full, ovf
  );

  modport slave (
    input  inp_valid, inp_data, rd_data, out_ready,
    output inp_ready, wr_addr, wr_en, wr_data, rd_addr, rd_en,
           out_valid, out_data, out_last, bank_full, ovf
  );

endinterface

// File: rtl/trps_bank_ctrl.sv
// Ping-pong 8x8 block transposer: fills one DPSRAM bank row-major while the
// other is read back column-major; the RAM itself sits outside this block.
module trps_bank_ctrl
  import fht_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           sclk,
  input  logic           rst,
  trps_bank_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_WORDS - 1);

  logic             r_wb;
  logic             r_rb;
  logic [CNT_W-1:0] r_wc;
  logic [CNT_W-1:0] r_rc;
  logic [1:0]       r_bank_full;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_ovf;

  logic              w_inp_ready;
  logic              w_accept;
  logic              w_issue;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [1:0]        w_bank_full_nxt;
  logic [RAM_DW-1:0] w_wr_data;

  assign w_inp_ready = ~r_bank_full[r_wb];
  // Gating with rst keeps the write strobe quiet while the controller is held in reset.
  assign w_accept    = bus.inp_valid & w_inp_ready & ~rst;
  assign w_issue     = r_bank_full[r_rb] & (~r_out_valid | bus.out_ready);
  assign w_wr_last   = (r_wc == CNT_LAST);
  assign w_rd_last   = (r_rc == CNT_LAST);

  always_comb begin
    w_wr_data         = '0;
    w_wr_data[N-1:0]  = bus.inp_data;
  end

  // Fill and drain always target different banks, so both edits can land in one cycle.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_accept && w_wr_last) begin
      w_bank_full_nxt[r_wb] = 1'b1;
    end
    if (w_issue && w_rd_last) begin
      w_bank_full_nxt[r_rb] = 1'b0;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_wc        <= '0;
      r_rc        <= '0;
      r_bank_full <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (w_accept) begin
        r_wc <= r_wc + 1'b1;
        if (w_wr_last) begin
          r_wb <= ~r_wb;
        end
      end
      if (w_issue) begin
        r_rc       <= r_rc + 1'b1;
        r_out_last <= w_rd_last;
        if (w_rd_last) begin
          r_rb <= ~r_rb;
        end
      end
      // RAM data arrives one cycle after the issue, matching this valid flag.
      if (w_issue) begin
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (bus.inp_valid && !w_inp_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.inp_ready = w_inp_ready;
  assign bus.wr_en     = w_accept;
  assign bus.wr_addr   = {r_wb, r_wc};
  assign bus.wr_data   = w_wr_data;
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = trps_addr(r_rb, r_rc);
  // The RAM holds its output while rd_en is low, so a stalled word stays put.
  assign bus.out_data  = bus.rd_data[N-1:0];
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.bank_full = r_bank_full;
  assign bus.ovf       = r_ovf;

endmodule
